// File: rtl/shift_pkg.sv
// Shared types for the shift-share sequencer: operand width, op encoding, FSM states.
package shift_pkg;
    localparam int XLEN = 32;

    typedef enum logic [1:0] {
        SRL = 2'b00,
        SRA = 2'b01,
        SLL = 2'b10,
        RSV = 2'b11
    } shift_op_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        RESP  = 2'd2
    } shift_state_e;
endpackage

// File: rtl/shift_share_ctrl_if.sv
// Request/response bundle between the two requesters (ALU, FP align) and the shared shifter.
interface shift_share_ctrl_if;
    logic [1:0]        req_valid_i;
    logic [1:0]        req_ready_o;
    logic [1:0][1:0]   req_op_i;
    logic [1:0][31:0]  req_data_i;
    logic [1:0][4:0]   req_shamt_i;
    logic [1:0]        rsp_valid_o;
    logic [1:0]        rsp_ready_i;
    logic [31:0]       rsp_data_o;
    logic              busy_o;

    modport slave (
        input  req_valid_i, req_op_i, req_data_i, req_shamt_i, rsp_ready_i,
        output req_ready_o, rsp_valid_o, rsp_data_o, busy_o
    );

    modport master (
        output req_valid_i, req_op_i, req_data_i, req_shamt_i, rsp_ready_i,
        input  req_ready_o, rsp_valid_o, rsp_data_o, busy_o
    );
endinterface

// File: rtl/reverse_32bit.sv
// Bit-order reversal of a 32-bit word; used to turn left shifts into right shifts.
module reverse_32bit (
    input  logic [31:0] bits,
    output logic [31:0] rev
);
    for (genvar i = 0; i < 32; i++) begin : g_rev
        assign rev[i] = bits[31-i];
    end
endmodule

// File: rtl/shift_rr_arb2.sv
// Combinational 2-way round-robin grant; the requester other than rr_last wins a tie.
module shift_rr_arb2 (
    input  logic [1:0] valid,
    input  logic       rr_last,
    output logic [1:0] grant
);
    always_comb begin
        grant = valid;
        if (valid == 2'b11)
            grant = rr_last ? 2'b01 : 2'b10;
    end
endmodule

// File: rtl/shift_share_ctrl.sv
// Shares one iterative right-shift datapath between two requesters (IDLE/SHIFT/RESP FSM).
// Optional perf counters are enabled with the SHIFT_SHARE_PERF_EN macro.
module shift_share_ctrl
    import shift_pkg::*;
#(
    parameter int SHIFT_PER_CYC = 8
) (
    input  logic clk_i,
    input  logic rst_ni,
    shift_share_ctrl_if.slave bus
`ifdef SHIFT_SHARE_PERF_EN
    ,
    output logic [31:0]      perf_busy_o,
    output logic [1:0][15:0] perf_grant_o
`endif
);
    // rem is 6 bits so a full 32-bit step is representable
    localparam logic [5:0] STEP_MAX = 6'(SHIFT_PER_CYC);

    shift_state_e    state;
    shift_op_e       op;
    logic            owner;
    logic            rr_last;
    logic            fill;
    logic [XLEN-1:0] work;
    logic [5:0]      rem;

    logic [1:0]      grant;
    logic            gidx;
    logic            accept;
    shift_op_e       req_op;
    logic [XLEN-1:0] req_data;
    logic [XLEN-1:0] req_rev;
    logic [XLEN-1:0] work_rev;
    logic [XLEN-1:0] shifted;
    logic [5:0]      step;

    shift_rr_arb2 u_arb (
        .valid   (bus.req_valid_i),
        .rr_last (rr_last),
        .grant   (grant)
    );

    assign gidx     = grant[1];
    assign accept   = (state == IDLE) && (grant != 2'b00);
    assign req_op   = shift_op_e'(bus.req_op_i[gidx]);
    assign req_data = bus.req_data_i[gidx];

    reverse_32bit u_rev_in  (.bits(req_data), .rev(req_rev));
    reverse_32bit u_rev_out (.bits(work),     .rev(work_rev));

    // Fill word sits above work so a step of 32 leaves only fill bits
    assign step    = (rem < STEP_MAX) ? rem : STEP_MAX;
    assign shifted = XLEN'({{XLEN{fill}}, work} >> step);

    assign bus.req_ready_o = (state == IDLE) ? grant : 2'b00;
    assign bus.rsp_valid_o = (state == RESP) ? (owner ? 2'b10 : 2'b01) : 2'b00;
    assign bus.rsp_data_o  = (state != RESP) ? '0 : ((op == SLL) ? work_rev : work);
    assign bus.busy_o      = (state != IDLE);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state   <= IDLE;
            op      <= SRL;
            owner   <= 1'b0;
            rr_last <= 1'b1;
            fill    <= 1'b0;
            work    <= '0;
            rem     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        owner <= gidx;
                        op    <= req_op;
                        work  <= (req_op == SLL) ? req_rev : req_data;
                        rem   <= {1'b0, bus.req_shamt_i[gidx]};
                        fill  <= (req_op == SRA) & req_data[XLEN-1];
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    work <= shifted;
                    rem  <= rem - step;
                    if (rem == step)
                        state <= RESP;
                end
                RESP: begin
                    if (bus.rsp_ready_i[owner]) begin
                        rr_last <= owner;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef SHIFT_SHARE_PERF_EN
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)
            perf_busy_o <= '0;
        else if (bus.busy_o && (perf_busy_o != '1))
            perf_busy_o <= perf_busy_o + 32'd1;
    end

    for (genvar g = 0; g < 2; g++) begin : g_perf
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni)
                perf_grant_o[g] <= '0;
            else if (accept && (gidx == 1'(g)) && (perf_grant_o[g] != '1))
                perf_grant_o[g] <= perf_grant_o[g] + 16'd1;
        end
    end
`endif
endmodule

// File: tb/tb_shift_share_ctrl.sv
// Self-checking bench for shift_share_ctrl: directed table, random vs. arithmetic model, corner sequences.
module tb_shift_share_ctrl;
    localparam int SPC = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    shift_share_ctrl_if bus();

    shift_share_ctrl #(.SHIFT_PER_CYC(SPC)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        int          r;
        logic [1:0]  op;
        logic [31:0] data;
        logic [4:0]  shamt;
        logic [31:0] exp_data;
        int          exp_n;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] d, input int sh);
        case (op)
            2'b10:   model = d << sh;
            2'b01:   model = $unsigned($signed(d) >>> sh);
            default: model = d >> sh;
        endcase
    endfunction

    function automatic int ncyc(input int sh);
        return (sh == 0) ? 1 : (sh + SPC - 1) / SPC;
    endfunction

    task automatic run_txn(input int r, input logic [1:0] op, input logic [31:0] d,
                           input logic [4:0] sh, input logic [31:0] exp_d, input int exp_n);
        int w;
        int lat;
        @(negedge clk);
        bus.req_valid_i[r] = 1'b1;
        bus.req_op_i[r]    = op;
        bus.req_data_i[r]  = d;
        bus.req_shamt_i[r] = sh;
        #1;
        w = 0;
        while (!bus.req_ready_o[r] && w < 50) begin
            @(negedge clk); #1;
            w++;
        end
        if (!bus.req_ready_o[r]) begin
            chk("req_ready_timeout", 32'(bus.req_ready_o[r]), 32'd1);
            bus.req_valid_i[r] = 1'b0;
            return;
        end
        @(posedge clk); #1;
        bus.req_valid_i[r] = 1'b0;
        lat = 0;
        while (!bus.rsp_valid_o[r] && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
        chk($sformatf("latency r%0d op%0d sh%0d", r, op, sh), 32'(lat), 32'(exp_n));
        chk($sformatf("rsp_data r%0d op%0d d%h sh%0d", r, op, d, sh), bus.rsp_data_o, exp_d);
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int          grants[$];
        int          done;
        int          owner;
        bit          both_seen;
        bit          rsp_seen;
        logic [31:0] rr_exp[2];
        logic [31:0] held;

        bus.req_valid_i = '0;
        bus.req_op_i    = '0;
        bus.req_data_i  = '0;
        bus.req_shamt_i = '0;
        bus.rsp_ready_i = 2'b11;

        vecs[0] = '{0, 2'b10, 32'h0000_0001, 5'd31, 32'h8000_0000, 4};
        vecs[1] = '{1, 2'b01, 32'h8000_0000, 5'd4,  32'hF800_0000, 1};
        vecs[2] = '{0, 2'b00, 32'hDEAD_BEEF, 5'd0,  32'hDEAD_BEEF, 1};
        vecs[3] = '{1, 2'b00, 32'hFFFF_FFFF, 5'd8,  32'h00FF_FFFF, 1};
        vecs[4] = '{1, 2'b11, 32'hF000_0000, 5'd4,  32'h0F00_0000, 1};
        vecs[5] = '{0, 2'b10, 32'h1234_5678, 5'd12, 32'h4567_8000, 2};
        vecs[6] = '{1, 2'b01, 32'h8000_0000, 5'd31, 32'hFFFF_FFFF, 4};

        #12;
        chk("rst_req_ready", 32'(bus.req_ready_o), 32'd0);
        chk("rst_rsp_valid", 32'(bus.rsp_valid_o), 32'd0);
        chk("rst_busy",      32'(bus.busy_o),      32'd0);
        chk("rst_rsp_data",  bus.rsp_data_o,       32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i])
            run_txn(vecs[i].r, vecs[i].op, vecs[i].data, vecs[i].shamt, vecs[i].exp_data, vecs[i].exp_n);

        for (int i = 0; i < 40; i++) begin
            int          r;
            logic [1:0]  op;
            logic [31:0] d;
            logic [4:0]  sh;
            r  = int'($urandom_range(0, 1));
            op = 2'($urandom_range(0, 3));
            d  = $urandom;
            sh = 5'($urandom_range(0, 31));
            run_txn(r, op, d, sh, model(op, d, int'(sh)), ncyc(int'(sh)));
        end

        // Both requesters valid from reset release: grants must alternate starting with 0
        @(negedge clk);
        rst_n = 1'b0;
        bus.req_op_i[0] = 2'b00; bus.req_data_i[0] = 32'h1111_0000; bus.req_shamt_i[0] = 5'd8;
        bus.req_op_i[1] = 2'b01; bus.req_data_i[1] = 32'h8000_0000; bus.req_shamt_i[1] = 5'd8;
        rr_exp[0] = model(2'b00, 32'h1111_0000, 8);
        rr_exp[1] = model(2'b01, 32'h8000_0000, 8);
        bus.req_valid_i = 2'b11;
        bus.rsp_ready_i = 2'b11;
        @(negedge clk);
        rst_n = 1'b1;
        done = 0;
        both_seen = 0;
        for (int cyc = 0; cyc < 200 && done < 8; cyc++) begin
            #1;
            if (bus.req_ready_o == 2'b11) both_seen = 1;
            if (bus.req_ready_o != 2'b00) grants.push_back(int'(bus.req_ready_o[1]));
            if ((bus.rsp_valid_o & bus.rsp_ready_i) != 2'b00) begin
                owner = int'(bus.rsp_valid_o[1]);
                chk($sformatf("rr_data%0d", done), bus.rsp_data_o, rr_exp[owner]);
                done++;
            end
            @(negedge clk);
        end
        bus.req_valid_i = 2'b00;
        chk("rr_done",       32'(done),          32'd8);
        chk("rr_both_ready", 32'(both_seen),     32'd0);
        chk("rr_grants",     32'(grants.size()), 32'd8);
        foreach (grants[i])
            chk($sformatf("rr_grant%0d", i), 32'(grants[i]), 32'(i % 2));

        // Response stall by owner 0; requester 1 waits and must not be granted
        @(negedge clk);
        bus.rsp_ready_i = 2'b10;
        bus.req_valid_i[0] = 1'b1; bus.req_op_i[0] = 2'b00;
        bus.req_data_i[0] = 32'h1234_5678; bus.req_shamt_i[0] = 5'd4;
        #1;
        chk("stall_accept_ready", 32'(bus.req_ready_o), 32'd1);
        @(posedge clk); #1;
        bus.req_valid_i[0] = 1'b0;
        @(posedge clk); #1;
        chk("stall_rsp_valid", 32'(bus.rsp_valid_o), 32'd1);
        chk("stall_rsp_data",  bus.rsp_data_o,       32'h0123_4567);
        held = bus.rsp_data_o;
        bus.req_valid_i[1] = 1'b1; bus.req_op_i[1] = 2'b00;
        bus.req_data_i[1] = 32'hFFFF_FFFF; bus.req_shamt_i[1] = 5'd8;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk($sformatf("stall_data%0d", i),  bus.rsp_data_o,       held);
            chk($sformatf("stall_ready%0d", i), 32'(bus.req_ready_o), 32'd0);
            chk($sformatf("stall_busy%0d", i),  32'(bus.busy_o),      32'd1);
            chk($sformatf("stall_valid%0d", i), 32'(bus.rsp_valid_o), 32'd1);
        end
        bus.rsp_ready_i[0] = 1'b1;
        @(posedge clk); #1;
        chk("unstall_busy",  32'(bus.busy_o),      32'd0);
        chk("unstall_valid", 32'(bus.rsp_valid_o), 32'd0);
        chk("unstall_ready", 32'(bus.req_ready_o), 32'd2);
        @(posedge clk); #1;
        bus.req_valid_i[1] = 1'b0;
        @(posedge clk); #1;
        chk("req1_rsp_valid", 32'(bus.rsp_valid_o), 32'd2);
        chk("req1_rsp_data",  bus.rsp_data_o,       32'h00FF_FFFF);
        @(posedge clk); #1;

        // Leave rr_last = 0 so only reset can explain requester 0 winning afterwards
        run_txn(0, 2'b00, 32'h0000_0005, 5'd1, 32'h0000_0002, 1);

        // Reset mid-SHIFT drops the transaction
        @(negedge clk);
        bus.req_valid_i[0] = 1'b1; bus.req_op_i[0] = 2'b10;
        bus.req_data_i[0] = 32'h0000_00FF; bus.req_shamt_i[0] = 5'd24;
        @(posedge clk); #1;
        bus.req_valid_i[0] = 1'b0;
        @(posedge clk); #1;
        chk("mid_shift_busy", 32'(bus.busy_o), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy",      32'(bus.busy_o),      32'd0);
        chk("mid_rst_rsp_valid", 32'(bus.rsp_valid_o), 32'd0);
        chk("mid_rst_rsp_data",  bus.rsp_data_o,       32'd0);
        chk("mid_rst_req_ready", 32'(bus.req_ready_o), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        bus.req_valid_i = 2'b11;
        #1;
        chk("post_rst_grant", 32'(bus.req_ready_o), 32'd1);
        bus.req_valid_i = 2'b00;
        rsp_seen = 0;
        repeat (8) begin
            @(posedge clk); #1;
            if (bus.rsp_valid_o != 2'b00 || bus.busy_o) rsp_seen = 1;
        end
        chk("post_rst_no_rsp", 32'(rsp_seen), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
